timing_mode_ctrl: RTL

TIMING_MODE_CTRL -- requirements
Module: timing_mode_ctrl

---
 rtl/vpg_pkg.sv | 45 ++++
 rtl/video_timing_rom.sv | 18 +
 rtl/timing_mode_ctrl.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/vpg_pkg.sv
// Shared types and constants for the video timing mode controller.
// Holds the FSM state encoding, mode codes and the three timing table entries.
package vpg_pkg;

  typedef enum logic [2:0] {
    STABLE_WAIT,
    RECONF,
    WAIT_LOCK,
    SETTLE,
    RUN
  } state_t;

  localparam logic [3:0] MODE_1080P60 = 4'd0;
  localparam logic [3:0] MODE_720P60  = 4'd1;
  localparam logic [3:0] MODE_480P60  = 4'd2;

  localparam int HOLDOFF_CYCLES = 256;

  typedef struct packed {
    logic [11:0] h_total;
    logic [11:0] h_sync;
    logic [11:0] h_start;
    logic [11:0] h_end;
    logic [11:0] v_total;
    logic [11:0] v_sync;
    logic [11:0] v_start;
    logic [11:0] v_end;
  } timing_t;

  localparam timing_t TIMING_1080P60 = '{
    h_total: 12'd2199, h_sync: 12'd43, h_start: 12'd189, h_end: 12'd2109,
    v_total: 12'd1124, v_sync: 12'd4,  v_start: 12'd40,  v_end: 12'd1120
  };

  localparam timing_t TIMING_720P60 = '{
    h_total: 12'd1649, h_sync: 12'd39, h_start: 12'd257, h_end: 12'd1537,
    v_total: 12'd749,  v_sync: 12'd4,  v_start: 12'd24,  v_end: 12'd744
  };

  localparam timing_t TIMING_480P60 = '{
    h_total: 12'd799, h_sync: 12'd95, h_start: 12'd141, h_end: 12'd781,
    v_total: 12'd524, v_sync: 12'd1,  v_start: 12'd34,  v_end: 12'd514
  };

endpackage

// File: rtl/video_timing_rom.sv
// Mode code to timing record lookup; purely combinational, zero latency, no flow control.
// Unlisted codes fall back to the 1080p60 entry.
module video_timing_rom
  import vpg_pkg::*;
(
  input  logic [3:0] mode,
  output timing_t    timing
);

  always_comb begin
    case (mode)
      MODE_720P60: timing = TIMING_720P60;
      MODE_480P60: timing = TIMING_480P60;
      default:     timing = TIMING_1080P60;
    endcase
  end

endmodule

// File: rtl/timing_mode_ctrl.sv
// Debounces the requested video mode, sequences PLL reconfiguration/lock and gates the pixel engine.
// Latency: STABLE_CYCLES to accept a mode, 256 + SETTLE_CYCLES after lock; no backpressure.
// Optional LOCK_TIMEOUT_EN: retry reconfiguration after LOCK_TIMEOUT cycles without lock, sticky lock_err.
module timing_mode_ctrl
  import vpg_pkg::*;
#(
  parameter int STABLE_CYCLES = 50000,
  parameter int SETTLE_CYCLES = 1024,
  parameter int LOCK_TIMEOUT  = 500000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  mode,
  input  logic        pll_locked,
  output logic [3:0]  pll_mode,
  output logic        pll_mode_change,
  output logic [11:0] h_total,
  output logic [11:0] h_sync,
  output logic [11:0] h_start,
  output logic [11:0] h_end,
  output logic [11:0] v_total,
  output logic [11:0] v_sync,
  output logic [11:0] v_start,
  output logic [11:0] v_end,
  output logic        engine_rst_n,
  output logic        busy,
  output logic        lock_err
);

  localparam logic [16:0] STABLE_LAST  = 17'(STABLE_CYCLES - 1);
  localparam logic [16:0] SETTLE_LAST  = 17'(SETTLE_CYCLES - 1);
  localparam logic [8:0]  HOLDOFF_DONE = 9'(HOLDOFF_CYCLES);

  if (STABLE_CYCLES < 1 || STABLE_CYCLES > 131072 ||
      SETTLE_CYCLES < 1 || SETTLE_CYCLES > 131072 ||
      LOCK_TIMEOUT < 1  || LOCK_TIMEOUT > 1048576) begin : g_param_check
    $error("timing_mode_ctrl: cycle parameter outside counter range");
  end

  logic [3:0]  mode_s1, mode_s, mode_prev;
  logic        locked_s1, locked_s;
  state_t      state;
  logic [16:0] stable_cnt;
  logic [16:0] settle_cnt;
  logic [8:0]  hold_cnt;
  timing_t     timing;
  timing_t     rom_timing;
  logic        timeout_hit;

  video_timing_rom u_rom (
    .mode   (pll_mode),
    .timing (rom_timing)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_s1   <= '0;
      mode_s    <= '0;
      locked_s1 <= 1'b0;
      locked_s  <= 1'b0;
    end else begin
      mode_s1   <= mode;
      mode_s    <= mode_s1;
      locked_s1 <= pll_locked;
      locked_s  <= locked_s1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= STABLE_WAIT;
      stable_cnt      <= '0;
      settle_cnt      <= '0;
      hold_cnt        <= '0;
      mode_prev       <= '0;
      pll_mode        <= '0;
      pll_mode_change <= 1'b0;
      timing          <= TIMING_1080P60;
      engine_rst_n    <= 1'b0;
    end else begin
      pll_mode_change <= 1'b0;
      engine_rst_n    <= 1'b0;
      mode_prev       <= mode_s;
      if (timeout_hit) begin
        pll_mode_change <= 1'b1;
        state           <= RECONF;
      end else begin
        case (state)
          STABLE_WAIT: begin
            if (mode_s != mode_prev) begin
              stable_cnt <= '0;
            end else if (stable_cnt == STABLE_LAST) begin
              pll_mode        <= mode_s;
              pll_mode_change <= 1'b1;
              stable_cnt      <= '0;
              state           <= RECONF;
            end else if (stable_cnt != '1) begin
              stable_cnt <= stable_cnt + 17'd1;
            end
          end
          RECONF: begin
            timing     <= rom_timing;
            hold_cnt   <= '0;
            settle_cnt <= '0;
            state      <= WAIT_LOCK;
          end
          WAIT_LOCK: begin
            if (hold_cnt != HOLDOFF_DONE) begin
              hold_cnt <= hold_cnt + 9'd1;
            end else if (locked_s) begin
              settle_cnt <= '0;
              state      <= SETTLE;
            end
          end
          SETTLE: begin
            // Lock loss after the PLL was already reconfigured needs no second holdoff.
            if (!locked_s) begin
              hold_cnt <= HOLDOFF_DONE;
              state    <= WAIT_LOCK;
            end else if (settle_cnt == SETTLE_LAST) begin
              state <= RUN;
            end else if (settle_cnt != '1) begin
              settle_cnt <= settle_cnt + 17'd1;
            end
          end
          RUN: begin
            if (!locked_s) begin
              hold_cnt <= HOLDOFF_DONE;
              state    <= WAIT_LOCK;
            end else if (mode_s != pll_mode) begin
              stable_cnt <= '0;
              state      <= STABLE_WAIT;
            end else begin
              engine_rst_n <= 1'b1;
            end
          end
          default: state <= STABLE_WAIT;
        endcase
      end
    end
  end

`ifdef LOCK_TIMEOUT_EN
  localparam logic [19:0] TIMEOUT_LAST = 20'(LOCK_TIMEOUT - 1);

  logic [19:0] timeout_cnt;
  logic [1:0]  timeout_num;
  logic        lock_err_q;

  assign timeout_hit = (state == WAIT_LOCK || state == SETTLE) && (timeout_cnt == TIMEOUT_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timeout_cnt <= '0;
      timeout_num <= '0;
      lock_err_q  <= 1'b0;
    end else begin
      if (state == WAIT_LOCK || state == SETTLE) begin
        if (timeout_hit) begin
          timeout_cnt <= '0;
        end else if (timeout_cnt != '1) begin
          timeout_cnt <= timeout_cnt + 20'd1;
        end
      end else begin
        timeout_cnt <= '0;
      end
      if (state == RUN) begin
        timeout_num <= '0;
        lock_err_q  <= 1'b0;
      end else if (timeout_hit) begin
        if (timeout_num != 2'd3) timeout_num <= timeout_num + 2'd1;
        if (timeout_num == 2'd2) lock_err_q <= 1'b1;
      end
    end
  end

  assign lock_err = lock_err_q;
`else
  assign timeout_hit = 1'b0;
  assign lock_err    = 1'b0;
`endif

  assign busy    = (state != RUN);
  assign h_total = timing.h_total;
  assign h_sync  = timing.h_sync;
  assign h_start = timing.h_start;
  assign h_end   = timing.h_end;
  assign v_total = timing.v_total;
  assign v_sync  = timing.v_sync;
  assign v_start = timing.v_start;
  assign v_end   = timing.v_end;

endmodule
